// File: rtl/wb_slave_to_avalon_master.sv
// Classic Wishbone slave to pipelined-read Avalon-MM master bridge, one transfer in flight.
// Optional WB_READ_TIMEOUT_EN adds a readdatavalid timeout with wb_err_o and late-response discard.
module wb_slave_to_avalon_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [DATA_BYTES-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic [DATA_BYTES-1:0] av_byteenable,
  output logic                  av_read,
  output logic                  av_write,
  output logic [DATA_WIDTH-1:0] av_writedata,
  input  logic [DATA_WIDTH-1:0] av_readdata,
  input  logic                  av_readdatavalid,
  input  logic                  av_waitrequest
);

  if (DATA_BYTES * 8 != DATA_WIDTH) begin : g_bad_bytes
    $error("DATA_BYTES must equal DATA_WIDTH/8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic                  read_nxt, write_nxt, ack_nxt, rdv_fresh;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_BYTES-1:0] be_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;

`ifdef WB_READ_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stale, stale_nxt, err_nxt;
`endif

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_nxt = state;
    read_nxt  = av_read;
    write_nxt = av_write;
    addr_nxt  = av_address;
    be_nxt    = av_byteenable;
    wdata_nxt = av_writedata;
    rdata_nxt = wb_dat_o;
    ack_nxt   = 1'b0;
    rdv_fresh = av_readdatavalid;
`ifdef WB_READ_TIMEOUT_EN
    cnt_nxt   = cnt;
    stale_nxt = stale;
    err_nxt   = 1'b0;
    // A response owed to a timed-out read is swallowed wherever it shows up
    if (stale && av_readdatavalid) begin
      stale_nxt = 1'b0;
      rdv_fresh = 1'b0;
    end
`endif
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_nxt  = wb_adr_i;
          be_nxt    = wb_sel_i;
          wdata_nxt = wb_dat_i;
          read_nxt  = ~wb_we_i;
          write_nxt = wb_we_i;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (!av_waitrequest) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (av_write) begin
            ack_nxt   = wb_cyc_i;
            state_nxt = RESP;
          end else begin
            state_nxt = RDWAIT;
          end
`ifdef WB_READ_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end
      end
      RDWAIT: begin
        if (rdv_fresh) begin
          rdata_nxt = av_readdata;
          ack_nxt   = wb_cyc_i;
          state_nxt = RESP;
        end
`ifdef WB_READ_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = wb_cyc_i;
          stale_nxt = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      av_read       <= 1'b0;
      av_write      <= 1'b0;
      av_address    <= '0;
      av_byteenable <= '0;
      av_writedata  <= '0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
`ifdef WB_READ_TIMEOUT_EN
      cnt           <= '0;
      stale         <= 1'b0;
      wb_err_o      <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      av_read       <= read_nxt;
      av_write      <= write_nxt;
      av_address    <= addr_nxt;
      av_byteenable <= be_nxt;
      av_writedata  <= wdata_nxt;
      wb_dat_o      <= rdata_nxt;
      wb_ack_o      <= ack_nxt;
`ifdef WB_READ_TIMEOUT_EN
      cnt           <= cnt_nxt;
      stale         <= stale_nxt;
      wb_err_o      <= err_nxt;
`endif
    end
  end

`ifndef WB_READ_TIMEOUT_EN
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_to_avalon_master.sv
// Directed bench for wb_slave_to_avalon_master: transaction-level model compared every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_wb_slave_to_avalon_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DB-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [AW-1:0] av_address;
  logic [DB-1:0] av_byteenable;
  logic          av_read, av_write;
  logic [DW-1:0] av_writedata;
  logic [DW-1:0] av_readdata;
  logic          av_readdatavalid, av_waitrequest;

  always #5 clk = ~clk;

  wb_slave_to_avalon_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .av_address(av_address), .av_byteenable(av_byteenable),
    .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_waitrequest(av_waitrequest)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: expected outputs, updated at each rising edge
  logic          exp_rd = 1'b0, exp_wr = 1'b0, exp_ack = 1'b0, exp_err = 1'b0;
  logic [AW-1:0] exp_adr = '0;
  logic [DB-1:0] exp_be = '0;
  logic [DW-1:0] exp_wdat = '0, exp_dat = '0;
  bit            m_stale = 1'b0;
  bit            mdl_reset = 1'b0;

  always @(negedge rst_n) begin
    mdl_reset = 1'b1;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    exp_adr = '0; exp_be = '0; exp_wdat = '0; exp_dat = '0;
    m_stale = 1'b0;
  end

  task automatic mdl_tick(output bit hit);
    @(posedge clk);
    hit = 1'b0;
    if (!mdl_reset && m_stale && av_readdatavalid) begin
      m_stale = 1'b0;
      hit     = 1'b1;
    end
  endtask

  task automatic mdl_run();
    bit hit, rd, to;
`ifdef WB_READ_TIMEOUT_EN
    int unsigned n;
`endif
    forever begin
      do begin
        mdl_tick(hit);
        if (mdl_reset) return;
      end while (!(wb_cyc_i && wb_stb_i));
      exp_adr  = wb_adr_i;
      exp_be   = wb_sel_i;
      exp_wdat = wb_dat_i;
      rd       = !wb_we_i;
      exp_rd   = rd;
      exp_wr   = !rd;
      do begin
        mdl_tick(hit);
        if (mdl_reset) return;
      end while (av_waitrequest);
      exp_rd = 1'b0;
      exp_wr = 1'b0;
      to     = 1'b0;
      if (rd) begin
`ifdef WB_READ_TIMEOUT_EN
        n = 0;
`endif
        forever begin
          mdl_tick(hit);
          if (mdl_reset) return;
          if (av_readdatavalid && !hit) begin
            exp_dat = av_readdata;
            break;
          end
`ifdef WB_READ_TIMEOUT_EN
          if (n == TO - 1) begin
            to      = 1'b1;
            m_stale = 1'b1;
            break;
          end
          n++;
`endif
        end
      end
      exp_ack = wb_cyc_i && !to;
      exp_err = wb_cyc_i && to;
      mdl_tick(hit);
      if (mdl_reset) return;
      exp_ack = 1'b0;
      exp_err = 1'b0;
    end
  endtask

  initial begin
    forever begin
      wait (rst_n === 1'b1);
      mdl_reset = 1'b0;
      mdl_run();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_av_read", 64'(av_read), 64'(exp_rd));
    chk("cyc_av_write", 64'(av_write), 64'(exp_wr));
    chk("cyc_av_address", 64'(av_address), 64'(exp_adr));
    chk("cyc_av_byteenable", 64'(av_byteenable), 64'(exp_be));
    chk("cyc_av_writedata", 64'(av_writedata), 64'(exp_wdat));
    chk("cyc_wb_dat_o", 64'(wb_dat_o), 64'(exp_dat));
    chk("cyc_wb_ack_o", 64'(wb_ack_o), 64'(exp_ack));
    chk("cyc_wb_err_o", 64'(wb_err_o), 64'(exp_err));
  end

  int wr_cycles = 0, rd_cycles = 0, ack_cycles = 0;
  always @(negedge clk) begin
    if (av_write) wr_cycles++;
    if (av_read)  rd_cycles++;
    if (wb_ack_o) ack_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DB-1:0] s);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
  endtask

  task automatic drop_req();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  int w0, r0, a0;

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    av_readdata = '0; av_readdatavalid = 1'b0; av_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_av_read", 64'(av_read), 64'd0);
    chk("rst_av_write", 64'(av_write), 64'd0);
    chk("rst_ack", 64'(wb_ack_o), 64'd0);
    rst_n = 1'b1;

    // 1: write, no stalls
    @(negedge clk);
    drive_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t1_av_write", 64'(av_write), 64'(c == 1));
      chk("t1_ack", 64'(wb_ack_o), 64'(c == 2));
      if (c == 1) begin
        chk("t1_addr", 64'(av_address), 64'h100);
        chk("t1_wdata", 64'(av_writedata), 64'hDEADBEEF);
        chk("t1_be", 64'(av_byteenable), 64'hF);
      end
      if (c == 2) drop_req();
    end

    // 2: read, three wait states, data two cycles after acceptance
    drive_req(1'b0, 32'h200, 32'h0, 4'hF);
    av_waitrequest = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t2_av_read", 64'(av_read), 64'(c <= 4));
      chk("t2_ack", 64'(wb_ack_o), 64'(c == 7));
      if (c == 7) begin
        chk("t2_rdata", 64'(wb_dat_o), 64'h12345678);
        drop_req();
      end
      av_waitrequest   = (c < 4);
      av_readdatavalid = (c == 6);
      av_readdata      = (c == 6) ? 32'h12345678 : 32'h0;
    end
    av_waitrequest = 1'b0;

    // 3: back-to-back write then read
    w0 = wr_cycles; r0 = rd_cycles; a0 = ack_cycles;
    drive_req(1'b1, 32'h10, 32'h00001010, 4'h3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("t3_ack_wr", 64'(wb_ack_o), 64'd1);
        drive_req(1'b0, 32'h14, 32'h0, 4'hF);
      end
      if (c == 4) chk("t3_rd_addr", 64'(av_address), 64'h14);
      if (c == 6) begin
        chk("t3_ack_rd", 64'(wb_ack_o), 64'd1);
        chk("t3_rdata", 64'(wb_dat_o), 64'hA5A50014);
        drop_req();
      end
      av_readdatavalid = (c == 5);
      av_readdata      = 32'hA5A50014;
    end
    chk("t3_write_cmds", 64'(wr_cycles - w0), 64'd1);
    chk("t3_read_cmds", 64'(rd_cycles - r0), 64'd1);
    chk("t3_acks", 64'(ack_cycles - a0), 64'd2);

    // 4: master aborts while the read is stalled
    a0 = ack_cycles;
    drive_req(1'b0, 32'h300, 32'h0, 4'hF);
    av_waitrequest = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("t4_av_read", 64'(av_read), 64'(c <= 5));
      if (c == 2) drop_req();
      av_waitrequest   = (c < 5);
      av_readdatavalid = (c == 7);
      av_readdata      = 32'h0BAD0BAD;
    end
    chk("t4_no_ack", 64'(ack_cycles - a0), 64'd0);
    chk("t4_rdata", 64'(wb_dat_o), 64'h0BAD0BAD);
    av_waitrequest = 1'b0;

    // 5: reset while waiting for read data, then a stalled write
    drive_req(1'b0, 32'h400, 32'h0, 4'hC);
    @(negedge clk);
    chk("t5_av_read", 64'(av_read), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_read", 64'(av_read), 64'd0);
    chk("t5_rst_write", 64'(av_write), 64'd0);
    chk("t5_rst_addr", 64'(av_address), 64'd0);
    chk("t5_rst_be", 64'(av_byteenable), 64'd0);
    chk("t5_rst_wdata", 64'(av_writedata), 64'd0);
    chk("t5_rst_rdata", 64'(wb_dat_o), 64'd0);
    chk("t5_rst_ack", 64'(wb_ack_o), 64'd0);
    chk("t5_rst_err", 64'(wb_err_o), 64'd0);
    @(negedge clk);
    drop_req();
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(1'b1, 32'h500, 32'h55AA55AA, 4'hF);
    av_waitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t5_av_write", 64'(av_write), 64'(c <= 2));
      chk("t5_ack", 64'(wb_ack_o), 64'(c == 3));
      if (c == 3) drop_req();
      av_waitrequest = (c < 2);
    end
    av_waitrequest = 1'b0;

`ifdef WB_READ_TIMEOUT_EN
    // 6: read timeout, then a late response landing in the next read
    drive_req(1'b0, 32'h600, 32'h0, 4'hF);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("t6_err", 64'(wb_err_o), 64'(c == 18));
      chk("t6_no_ack", 64'(wb_ack_o), 64'd0);
      if (c == 18) drop_req();
    end
    drive_req(1'b0, 32'h604, 32'h0, 4'hF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("t6_ack", 64'(wb_ack_o), 64'd1);
        chk("t6_rdata", 64'(wb_dat_o), 64'h600D0604);
        drop_req();
      end
      av_readdatavalid = (c == 2) || (c == 3);
      av_readdata      = (c == 2) ? 32'hBAADF00D : 32'h600D0604;
    end
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
